// File: rtl/puf_pkg.sv
// Shared types, width helper and default sizing for the PUF sampling slice.
package puf_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRST = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int unsigned DEF_N_PUF      = 32'd8;
    localparam int unsigned DEF_N_EVAL     = 32'd15;
    localparam int unsigned DEF_RESET_CYC  = 32'd4;
    localparam int unsigned DEF_SETTLE_CYC = 32'd16;

    // Bits needed to count 0..max_val-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val <= 32'd1) begin
            cnt_width = 32'd1;
        end else begin
            cnt_width = $clog2(max_val);
        end
    endfunction

endpackage

// File: rtl/puf_sync.sv
// Two-flop synchronizer for the asynchronous PUF cell outputs.
module puf_sync #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Metastability capture stage followed by the stable stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/puf_sampler.sv
// Sequences reset/start of a PUF cell array, samples N_EVAL evaluations and
// produces a majority-voted response with per-bit instability flags.
module puf_sampler
    import puf_pkg::*;
#(
    parameter int unsigned N_PUF      = DEF_N_PUF,
    parameter int unsigned N_EVAL     = DEF_N_EVAL,
    parameter int unsigned RESET_CYC  = DEF_RESET_CYC,
    parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [N_PUF-1:0] puf_out,
    output logic             puf_start,
    output logic             puf_reset,
    output logic             busy,
    output logic             resp_valid,
    output logic [N_PUF-1:0] resp,
    output logic [N_PUF-1:0] unstable
);

    localparam int unsigned PH_MAX = (RESET_CYC > SETTLE_CYC) ? RESET_CYC : SETTLE_CYC;
    localparam int unsigned PH_W   = cnt_width(PH_MAX);
    localparam int unsigned EV_W   = cnt_width(N_EVAL);
    localparam int unsigned CNT_W  = cnt_width(N_EVAL + 32'd1);

    localparam logic [PH_W-1:0]  PRST_LAST = PH_W'(RESET_CYC - 32'd1);
    localparam logic [PH_W-1:0]  RUN_LAST  = PH_W'(SETTLE_CYC - 32'd1);
    localparam logic [PH_W-1:0]  PH_ONE    = PH_W'(32'd1);
    localparam logic [EV_W-1:0]  EV_LAST   = EV_W'(N_EVAL - 32'd1);
    localparam logic [EV_W-1:0]  EV_ONE    = EV_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(N_EVAL / 32'd2);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(N_EVAL);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(32'd0);

    state_t           state_r;
    state_t           state_next_s;
    logic [PH_W-1:0]  phase_r;
    logic [EV_W-1:0]  eval_r;
    logic [CNT_W-1:0] count_r [N_PUF];
    logic [N_PUF-1:0] sync_s;
    logic             start_meas_s;
    logic             sample_s;
    logic [N_PUF-1:0] resp_next_s;
    logic [N_PUF-1:0] unstable_next_s;

    logic             puf_start_r;
    logic             puf_reset_r;
    logic             busy_r;
    logic             resp_valid_r;
    logic [N_PUF-1:0] resp_r;
    logic [N_PUF-1:0] unstable_r;

    puf_sync #(.WIDTH(N_PUF)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (puf_out),
        .q     (sync_s)
    );

    // Next-state decode for the evaluation sequencer.
    always_comb begin
        state_next_s = state_r;
        start_meas_s = 1'b0;
        sample_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (req) begin
                    state_next_s = S_PRST;
                    start_meas_s = 1'b1;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_PRST: begin
                if (phase_r == PRST_LAST) begin
                    state_next_s = S_RUN;
                end else begin
                    state_next_s = S_PRST;
                end
            end
            S_RUN: begin
                if (phase_r == RUN_LAST) begin
                    sample_s = 1'b1;
                    if (eval_r == EV_LAST) begin
                        state_next_s = S_DONE;
                    end else begin
                        state_next_s = S_PRST;
                    end
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Majority vote and disagreement flags from the accumulated counts.
    always_comb begin
        resp_next_s     = {N_PUF{1'b0}};
        unstable_next_s = {N_PUF{1'b0}};
        for (int i = 0; i < int'(N_PUF); i++) begin
            resp_next_s[i]     = (count_r[i] > CNT_HALF);
            unstable_next_s[i] = (count_r[i] != CNT_ZERO) && (count_r[i] != CNT_FULL);
        end
    end

    // State, phase and evaluation counters; phase restarts on every state change.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            phase_r <= {PH_W{1'b0}};
            eval_r  <= {EV_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if ((state_r == S_IDLE) || (state_next_s != state_r)) begin
                phase_r <= {PH_W{1'b0}};
            end else begin
                phase_r <= phase_r + PH_ONE;
            end
            if (start_meas_s) begin
                eval_r <= {EV_W{1'b0}};
            end else if (sample_s && (eval_r != EV_LAST)) begin
                eval_r <= eval_r + EV_ONE;
            end else begin
                eval_r <= eval_r;
            end
        end
    end

    // Per-cell ones counters, updated from the synchronizer in the last RUN cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(N_PUF); i++) begin
            if (reset || start_meas_s) begin
                count_r[i] <= CNT_ZERO;
            end else if (sample_s) begin
                count_r[i] <= count_r[i] + CNT_W'(sync_s[i]);
            end else begin
                count_r[i] <= count_r[i];
            end
        end
    end

    // Registered outputs; busy trails the state by one cycle so it drops with resp_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            puf_reset_r  <= 1'b1;
            puf_start_r  <= 1'b0;
            busy_r       <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_r       <= {N_PUF{1'b0}};
            unstable_r   <= {N_PUF{1'b0}};
        end else begin
            puf_reset_r  <= (state_next_s != S_RUN);
            puf_start_r  <= (state_next_s == S_RUN);
            busy_r       <= (state_r == S_PRST) || (state_r == S_RUN);
            resp_valid_r <= (state_r == S_DONE);
            if (state_r == S_DONE) begin
                resp_r     <= resp_next_s;
                unstable_r <= unstable_next_s;
            end else begin
                resp_r     <= resp_r;
                unstable_r <= unstable_r;
            end
        end
    end

    assign puf_start  = puf_start_r;
    assign puf_reset  = puf_reset_r;
    assign busy       = busy_r;
    assign resp_valid = resp_valid_r;
    assign resp       = resp_r;
    assign unstable   = unstable_r;

endmodule
